// File: rtl/rlwe_poly_mem_responder_if.sv
// Host request/response channel of the RLWE polynomial memory.
// The host issues single-word reads and writes while it owns the banks.
interface rlwe_poly_mem_responder_if #(
    parameter int ADDR_W = 11,
    parameter int COEF_W = 30
) ();
    logic                  host_valid;
    logic                  host_ready;
    logic                  host_we;
    logic [1:0]            host_sel;
    logic [ADDR_W-1:0]     host_addr;
    logic [2*COEF_W-1:0]   host_wdata;
    logic                  host_rvalid;
    logic [2*COEF_W-1:0]   host_rdata;

    modport master (
        output host_valid, host_we, host_sel, host_addr, host_wdata,
        input  host_ready, host_rvalid, host_rdata
    );

    modport slave (
        input  host_valid, host_we, host_sel, host_addr, host_wdata,
        output host_ready, host_rvalid, host_rdata
    );
endinterface

// File: rtl/rlwe_poly_mem_responder.sv
// Banked coefficient-pair memory shared between the NTT processor and a host.
// One-entry write stage, 2-cycle read pipeline, read-first with bypass of the committing write.
module rlwe_poly_mem_responder #(
    parameter int ADDR_W = 11,
    parameter int COEF_W = 30,
    parameter int NBANK  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    host_mode,
    input  logic [1:0]              rdMsel,
    input  logic [1:0]              wtMsel,
    input  logic                    ram_write_en_r,
    input  logic [ADDR_W-1:0]       write_address,
    input  logic [ADDR_W-1:0]       read_address,
    input  logic [COEF_W-1:0]       din_high,
    input  logic [COEF_W-1:0]       din_low,
    output logic [2*COEF_W-1:0]     doutb,
    rlwe_poly_mem_responder_if.slave host
);
    localparam int WORD_W = 2 * COEF_W;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct packed {
        logic              vld;
        logic [1:0]        sel;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wr_entry_t;

    typedef struct packed {
        logic              host;
        logic [WORD_W-1:0] data;
    } rd_stage_t;

    logic [WORD_W-1:0] mem_q [NBANK*DEPTH];

    wr_entry_t         wr_q, wr_d;
    rd_stage_t         s1_q, s2_q;
    logic [1:0]        vld_pipe_q;
    logic              host_ready_q;
    logic [WORD_W-1:0] doutb_q;
    logic [WORD_W-1:0] host_rdata_q;
    logic              host_rvalid_q;

    logic              own_host;
    logic              rd_vld;
    logic [1:0]        rd_sel;
    logic [ADDR_W-1:0] rd_addr;
    logic              fwd;

    // Port ownership follows the registered mode, so a mode flip takes one cycle.
    always_comb begin
        own_host = host_ready_q;
        rd_vld   = 1'b1;
        rd_sel   = rdMsel;
        rd_addr  = read_address;
        wr_d     = '0;
        if (own_host) begin
            rd_vld     = host.host_valid & ~host.host_we;
            rd_sel     = host.host_sel;
            rd_addr    = host.host_addr;
            wr_d.vld   = host.host_valid & host.host_we;
            wr_d.sel   = host.host_sel;
            wr_d.addr  = host.host_addr;
            wr_d.data  = host.host_wdata;
        end else begin
            wr_d.vld   = ram_write_en_r;
            wr_d.sel   = wtMsel;
            wr_d.addr  = write_address;
            wr_d.data  = {din_high, din_low};
        end
        fwd = wr_q.vld && (wr_q.sel == rd_sel) && (wr_q.addr == rd_addr);
    end

    // Array is never reset; a write pending at a reset edge is simply dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_q.vld) begin
            mem_q[{wr_q.sel, wr_q.addr}] <= wr_q.data;
        end
    end

    // The array still shows pre-commit data at the sampling edge, so bypass the
    // entry committing on that same edge; the entry captured now stays invisible.
    always_ff @(posedge clk) begin
        s1_q.host <= own_host;
        s1_q.data <= fwd ? wr_q.data : mem_q[{rd_sel, rd_addr}];
        s2_q      <= s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            host_ready_q  <= 1'b0;
            wr_q          <= '0;
            vld_pipe_q    <= '0;
            doutb_q       <= '0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            host_ready_q  <= host_mode;
            wr_q          <= wr_d;
            vld_pipe_q    <= {vld_pipe_q[0], rd_vld};
            host_rvalid_q <= vld_pipe_q[1] & s2_q.host;
            // Responses return on the port that issued them, even across a mode flip.
            if (vld_pipe_q[1]) begin
                if (s2_q.host) begin
                    host_rdata_q <= s2_q.data;
                end else begin
                    doutb_q <= s2_q.data;
                end
            end
        end
    end

    assign doutb            = doutb_q;
    assign host.host_ready  = host_ready_q;
    assign host.host_rvalid = host_rvalid_q;
    assign host.host_rdata  = host_rdata_q;
endmodule

// File: doc/rlwe_poly_mem_responder.md
RLWE_POLY_MEM_RESPONDER -- requirements
Module: rlwe_poly_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, coefficient-pair address width (depth 2^ADDR_W).
REQ-002 SHALL have parameter COEF_W, default 30, width of one residue coefficient.
REQ-003 SHALL have parameter NBANK, default 4, number of polynomial banks selected by rdMsel/wtMsel.
REQ-004 SHALL have port clk  in  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port host_mode  in  1  1 = host port owns the banks, 0 = processor port owns them.
REQ-007 SHALL have port rdMsel  in  2  processor read bank select.
REQ-008 SHALL have port wtMsel  in  2  processor write bank select.
REQ-009 SHALL have port ram_write_en_r  in  1  processor write strobe.
REQ-010 SHALL have port write_address  in  ADDR_W  processor write address.
REQ-011 SHALL have port read_address  in  ADDR_W  processor read address, sampled every cycle.
REQ-012 SHALL have port din_high  in  COEF_W  processor write data, upper coefficient.
REQ-013 SHALL have port din_low  in  COEF_W  processor write data, lower coefficient.
REQ-014 SHALL have port doutb  out  2*COEF_W  processor read data {high,low}.
REQ-015 SHALL have ports host_valid in 1, host_ready out 1, host_we in 1, host_sel in 2, host_addr in ADDR_W, host_wdata in 2*COEF_W: host request channel.
REQ-016 SHALL have ports host_rvalid out 1, host_rdata out 2*COEF_W: host read response.

Function
REQ-017 SHALL store NBANK x 2^ADDR_W words of 2*COEF_W bits; word = {high[59:30], low[29:0]}.
REQ-018 SHALL accept a host request only on a cycle with host_valid=1 and host_ready=1; host_ready SHALL equal host_mode registered (1 the cycle after host_mode rises, 0 the cycle after it falls).
REQ-019 SHALL, when host_mode=0, capture {wtMsel, write_address, din_high, din_low} into a one-entry write stage at edge T when ram_write_en_r=1, and commit it to the array at edge T+1.
REQ-020 SHALL, when accepting a host write, capture {host_sel, host_addr, host_wdata} into the same write stage with the same T/T+1 timing.
REQ-021 SHALL ignore ram_write_en_r while host_mode=0 is not in effect (i.e. host_ready=1).
REQ-022 SHALL sample a processor read (rdMsel, read_address) every edge while host_ready=0 and present the word on doutb exactly 2 edges later (latency 2); doutb SHALL hold its last value while host_ready=1.
REQ-023 SHALL return an accepted host read on host_rdata with host_rvalid=1 for one cycle exactly 2 edges after acceptance; back-to-back reads SHALL give back-to-back responses in order.
REQ-024 SHALL forward write-stage data when a read sampled at edge T matches the bank and address of the write stage entry committing at edge T.
REQ-025 SHALL return pre-write contents for a read and a write to the same bank/address sampled at the same edge (read-first).
REQ-026 SHALL apply consecutive writes to the same location in order; last write wins, and forwarding SHALL use the newest entry.
REQ-027 SHALL let reads in flight at a host_mode change complete on the output of the port that issued them.
REQ-028 SHALL treat address wrap as none: addresses are used modulo 2^ADDR_W without range checks.

Reset
REQ-029 SHALL, on rst=1 at an edge, clear write-stage valid (pending write discarded, not committed), clear read pipeline valids, and set doutb=0, host_rdata=0, host_rvalid=0, host_ready=0.
REQ-030 SHALL NOT clear array contents on reset; reset mid-burst SHALL drop only uncommitted writes and in-flight reads.

Verification
REQ-031 Processor write bank 2 addr 5 {0x1,0x2}, then read bank 2 addr 5 two cycles later -> doutb=0x0000000_40000002 two edges after the read.
REQ-032 Write bank 1 addr 7 = A at edge T, read bank 1 addr 7 at edge T+1 -> doutb=A (forwarded) at T+3; read at edge T -> old value.
REQ-033 Writes A then B to bank 0 addr 0 on consecutive edges, read at next edge -> B.
REQ-034 host_mode=1, host reads addrs 0,1,2 back-to-back -> host_rvalid high 3 consecutive cycles, data in order; concurrent ram_write_en_r=1 -> array unchanged.
REQ-035 Write captured at edge T, rst=1 at edge T+1 -> location keeps old value; all outputs 0 after reset.
